// File: rtl/usb2_ulpi_reg_arb_if.sv
// Requester-side and ULPI-link-side signals of the register-access arbiter.
// The master modport is the arbiter's view; the slave modport is the view of the requesters and link.
interface usb2_ulpi_reg_arb_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_write;
    logic [NREQ*6-1:0] req_addr;
    logic [NREQ*8-1:0] req_wdata;
    logic [NREQ-1:0]   req_ack;
    logic              req_err;
    logic [7:0]        req_rdata;
    logic              link_busy;
    logic              cmd_valid;
    logic              cmd_write;
    logic [5:0]        cmd_addr;
    logic [7:0]        cmd_wdata;
    logic              cmd_ready;
    logic              cmd_done;
    logic [7:0]        cmd_rdata;
    logic [NREQ-1:0]   grant;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, link_busy,
               cmd_ready, cmd_done, cmd_rdata,
        output req_ack, req_err, req_rdata, cmd_valid, cmd_write,
               cmd_addr, cmd_wdata, grant
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, link_busy,
               cmd_ready, cmd_done, cmd_rdata,
        input  req_ack, req_err, req_rdata, cmd_valid, cmd_write,
               cmd_addr, cmd_wdata, grant
    );
endinterface

// File: rtl/usb2_ulpi_reg_arb.sv
// Round-robin arbiter sharing the ULPI register-access command port among NREQ requesters.
// Issues one command at a time, enforces a completion timeout and returns status and read data.
//
// state    | meaning
// ST_IDLE  | no owner; grant the next requester when the link is not busy
// ST_ISSUE | command presented on cmd_*, waiting for cmd_ready
// ST_WAIT  | command accepted, waiting for cmd_done or timeout
// ST_RESP  | one-cycle ack/err/rdata to the owner, advance rr_ptr
module usb2_ulpi_reg_arb #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic                phy_clk,
    input  logic                reset,
    usb2_ulpi_reg_arb_if.master bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NREQ - 1);
    localparam logic [CW-1:0] TO_CNT   = CW'(TIMEOUT);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]   win_q, win_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic            err_q, err_d;
    logic [7:0]      rdata_q, rdata_d;
    logic            cmd_valid_q, cmd_valid_d;
    logic            cmd_write_q, cmd_write_d;
    logic [5:0]      cmd_addr_q, cmd_addr_d;
    logic [7:0]      cmd_wdata_q, cmd_wdata_d;

    logic            found;
    logic [IW-1:0]   win_idx;
    logic [IW-1:0]   scan;
    int              pos;
    logic [NREQ-1:0] win_oh;
    logic            sel_write;
    logic [5:0]      sel_addr;
    logic [7:0]      sel_wdata;

    // First valid request at or above rr_ptr, wrapping past NREQ-1.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        scan    = '0;
        pos     = 0;
        for (int i = 0; i < NREQ; i++) begin
            pos = int'(rr_ptr_q) + i;
            if (pos >= NREQ) pos = pos - NREQ;
            scan = IW'(pos);
            if (!found && bus.req_valid[scan]) begin
                found   = 1'b1;
                win_idx = scan;
            end
        end
    end

    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        win_oh    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_idx == IW'(i)) begin
                sel_write = bus.req_write[i];
                sel_addr  = bus.req_addr[i*6 +: 6];
                sel_wdata = bus.req_wdata[i*8 +: 8];
                win_oh[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        win_d       = win_q;
        cnt_d       = cnt_q;
        grant_d     = grant_q;
        ack_d       = ack_q;
        err_d       = err_q;
        rdata_d     = rdata_q;
        cmd_valid_d = cmd_valid_q;
        cmd_write_d = cmd_write_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        unique case (state_q)
            ST_IDLE: begin
                if (found && !bus.link_busy) begin
                    state_d     = ST_ISSUE;
                    win_d       = win_idx;
                    grant_d     = win_oh;
                    cnt_d       = '0;
                    cmd_valid_d = 1'b1;
                    cmd_write_d = sel_write;
                    cmd_addr_d  = sel_addr;
                    cmd_wdata_d = sel_wdata;
                end
            end
            ST_ISSUE: begin
                if (bus.cmd_ready) begin
                    state_d     = ST_WAIT;
                    cmd_valid_d = 1'b0;
                    cnt_d       = '0;
                end else if (cnt_q == TO_CNT) begin
                    // A link that never accepts is treated like one that never completes.
                    state_d     = ST_RESP;
                    cmd_valid_d = 1'b0;
                    ack_d       = grant_q;
                    err_d       = 1'b1;
                    rdata_d     = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT: begin
                if (bus.cmd_done) begin
                    state_d = ST_RESP;
                    ack_d   = grant_q;
                    err_d   = 1'b0;
                    rdata_d = cmd_write_q ? 8'h00 : bus.cmd_rdata;
                end else if (cnt_q == TO_CNT) begin
                    state_d = ST_RESP;
                    ack_d   = grant_q;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                state_d  = ST_IDLE;
                ack_d    = '0;
                err_d    = 1'b0;
                rdata_d  = '0;
                grant_d  = '0;
                rr_ptr_d = (win_q == LAST_IDX) ? '0 : win_q + 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge phy_clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            win_q       <= '0;
            cnt_q       <= '0;
            grant_q     <= '0;
            ack_q       <= '0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            cmd_valid_q <= 1'b0;
            cmd_write_q <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            win_q       <= win_d;
            cnt_q       <= cnt_d;
            grant_q     <= grant_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_write_q <= cmd_write_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.req_ack   = ack_q;
    assign bus.req_err   = err_q;
    assign bus.req_rdata = rdata_q;
    assign bus.cmd_valid = cmd_valid_q;
    assign bus.cmd_write = cmd_write_q;
    assign bus.cmd_addr  = cmd_addr_q;
    assign bus.cmd_wdata = cmd_wdata_q;
endmodule
